pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_hazard_cmp.sv | 27 ++
 rtl/pipe_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared definitions for the pipeline controller: FSM state
//            encoding and the default RAM wait-cycle limit.
// Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller states; encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    // Default number of consecutive RAM wait cycles tolerated before timeout.
    localparam int unsigned WAIT_MAX_DEFAULT = 8;

    // Width of the stall statistics output.
    localparam int unsigned STALL_W = 16;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_cmp.sv
`default_nettype none
// ============================================================================
// Module   : hazard_cmp
// Purpose  : Load-use hazard detection. Flags when the instruction in EX is a
//            RAM read whose (non-zero) destination feeds a source of the
//            instruction in ID.
// Revision : 1.0  initial release
// ============================================================================
module hazard_cmp
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_e_read_ram,
    output logic                  o_hazard
);

    // Register 0 is hard-wired, so writing it never creates a dependency.
    assign o_hazard = i_ex_e_read_ram
                    & (i_ex_rd != '0)
                    & ((i_ex_rd == i_id_rs) | (i_ex_rd == i_id_rt));

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline stall/flush controller. Handles RAM wait states with a
//            timeout, taken-branch flushes and load-use bubbles. Outputs are
//            combinational from state and current inputs.
// Options  : PIPE_CTRL_STATS_EN - when defined, o_stall_cycles counts cycles
//            with the PC held (saturating); otherwise it is tied to zero.
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX   = WAIT_MAX_DEFAULT,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_e_read_ram,
    input  logic                  i_mem_req,
    input  logic                  i_ram_ready,
    input  logic                  i_branch_taken,
    output logic                  o_pc_en,
    output logic                  o_buf0_en,
    output logic                  o_buf1_en,
    output logic                  o_buf2_en,
    output logic                  o_buf0_flush,
    output logic                  o_buf1_flush,
    output logic                  o_error,
    output logic [STALL_W-1:0]    o_stall_cycles
);

    localparam int              CNT_W      = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] c_wait_max = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic [CNT_W-1:0] w_wait_inc;
    logic             r_branch_pending;
    logic             w_branch_pending_nxt;
    logic             w_mem_stall;
    logic             w_hazard;

    hazard_cmp #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_cmp (
        .i_id_rs         (i_id_rs),
        .i_id_rt         (i_id_rt),
        .i_ex_rd         (i_ex_rd),
        .i_ex_e_read_ram (i_ex_e_read_ram),
        .o_hazard        (w_hazard)
    );

    assign w_mem_stall = i_mem_req & ~i_ram_ready;

    // Wait counter increment, saturating so it can never wrap.
    assign w_wait_inc = (r_wait_cnt == c_wait_max) ? r_wait_cnt
                                                   : r_wait_cnt + c_cnt_one;

    // State, wait counter and deferred-branch flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= RUN;
            r_wait_cnt       <= '0;
            r_branch_pending <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_wait_cnt       <= w_wait_cnt_nxt;
            r_branch_pending <= w_branch_pending_nxt;
        end
    end

    // Next-state and same-cycle output decode; priority is RAM wait, then
    // taken branch, then load-use hazard.
    always_comb begin
        w_state_nxt          = r_state;
        w_wait_cnt_nxt       = r_wait_cnt;
        w_branch_pending_nxt = r_branch_pending;
        o_pc_en              = 1'b0;
        o_buf0_en            = 1'b0;
        o_buf1_en            = 1'b0;
        o_buf2_en            = 1'b0;
        o_buf0_flush         = 1'b0;
        o_buf1_flush         = 1'b0;
        o_error              = 1'b0;

        if (!rst_n) begin
            // Hold everything and fill the front buffers with bubbles.
            o_buf0_flush = 1'b1;
            o_buf1_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        w_state_nxt          = MEM_WAIT;
                        w_wait_cnt_nxt       = c_cnt_one;
                        w_branch_pending_nxt = i_branch_taken;
                    end else if (i_branch_taken) begin
                        o_pc_en      = 1'b1;
                        o_buf0_en    = 1'b1;
                        o_buf1_en    = 1'b1;
                        o_buf2_en    = 1'b1;
                        o_buf0_flush = 1'b1;
                        o_buf1_flush = 1'b1;
                    end else if (w_hazard) begin
                        // Hold PC and IF/ID one cycle, inject a bubble into EX.
                        o_buf1_en    = 1'b1;
                        o_buf2_en    = 1'b1;
                        o_buf1_flush = 1'b1;
                    end else begin
                        o_pc_en   = 1'b1;
                        o_buf0_en = 1'b1;
                        o_buf1_en = 1'b1;
                        o_buf2_en = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // Ready wins over a timeout landing in the same cycle.
                    if (i_ram_ready) begin
                        o_pc_en              = 1'b1;
                        o_buf0_en            = 1'b1;
                        o_buf1_en            = 1'b1;
                        o_buf2_en            = 1'b1;
                        o_buf0_flush         = r_branch_pending | i_branch_taken;
                        o_buf1_flush         = r_branch_pending | i_branch_taken;
                        w_state_nxt          = RUN;
                        w_wait_cnt_nxt       = '0;
                        w_branch_pending_nxt = 1'b0;
                    end else begin
                        w_wait_cnt_nxt       = w_wait_inc;
                        w_branch_pending_nxt = r_branch_pending | i_branch_taken;
                        if (w_wait_inc == c_wait_max) begin
                            w_state_nxt = ERROR;
                        end
                    end
                end
                ERROR: begin
                    o_error = 1'b1;
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [STALL_W-1:0] r_stall_cycles;

    // Count cycles with the PC held, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!o_pc_en && (r_stall_cycles != {STALL_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + STALL_W'(1);
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl: directed scenarios with literal
//            expectations followed by randomized traffic, all compared every
//            cycle against a behavioural model of the controller rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int WAIT_MAX = 8;
    localparam int RW       = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] i_id_rs = '0;
    logic [RW-1:0] i_id_rt = '0;
    logic [RW-1:0] i_ex_rd = '0;
    logic          i_ex_e_read_ram = 1'b0;
    logic          i_mem_req = 1'b0;
    logic          i_ram_ready = 1'b0;
    logic          i_branch_taken = 1'b0;
    logic          o_pc_en, o_buf0_en, o_buf1_en, o_buf2_en;
    logic          o_buf0_flush, o_buf1_flush, o_error;
    logic [15:0]   o_stall_cycles;

    logic [6:0]    act_ctrl;
    assign act_ctrl = {o_pc_en, o_buf0_en, o_buf1_en, o_buf2_en,
                       o_buf0_flush, o_buf1_flush, o_error};

    pipe_ctrl #(
        .WAIT_MAX   (WAIT_MAX),
        .REG_ADDR_W (RW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_id_rs         (i_id_rs),
        .i_id_rt         (i_id_rt),
        .i_ex_rd         (i_ex_rd),
        .i_ex_e_read_ram (i_ex_e_read_ram),
        .i_mem_req       (i_mem_req),
        .i_ram_ready     (i_ram_ready),
        .i_branch_taken  (i_branch_taken),
        .o_pc_en         (o_pc_en),
        .o_buf0_en       (o_buf0_en),
        .o_buf1_en       (o_buf1_en),
        .o_buf2_en       (o_buf2_en),
        .o_buf0_flush    (o_buf0_flush),
        .o_buf1_flush    (o_buf1_flush),
        .o_error         (o_error),
        .o_stall_cycles  (o_stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: number of wait cycles spent so far on the current
    // RAM access (0 = not waiting), a deferred branch, a dead flag after a
    // timeout, and the count of PC-held cycles.
    int         waits  = 0;
    bit         brp    = 1'b0;
    bit         dead   = 1'b0;
    int         stalls = 0;
    logic [6:0] exp_ctrl;
    logic [15:0] exp_stalls;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current inputs and model state.
    task automatic model_eval();
        bit m, h;
        m = i_mem_req && !i_ram_ready;
        h = i_ex_e_read_ram && (i_ex_rd != 0) && (i_ex_rd == i_id_rs || i_ex_rd == i_id_rt);
        if (!rst_n)                exp_ctrl = 7'b0000_11_0;
        else if (dead)             exp_ctrl = 7'b0000_00_1;
        else if (waits > 0) begin
            if (i_ram_ready)       exp_ctrl = (brp || i_branch_taken) ? 7'b1111_11_0 : 7'b1111_00_0;
            else                   exp_ctrl = 7'b0000_00_0;
        end
        else if (m)                exp_ctrl = 7'b0000_00_0;
        else if (i_branch_taken)   exp_ctrl = 7'b1111_11_0;
        else if (h)                exp_ctrl = 7'b0011_01_0;
        else                       exp_ctrl = 7'b1111_00_0;
`ifdef PIPE_CTRL_STATS_EN
        exp_stalls = 16'(stalls);
`else
        exp_stalls = 16'd0;
`endif
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_next();
        if (!rst_n) begin
            waits = 0; brp = 1'b0; dead = 1'b0; stalls = 0;
        end else begin
            if (exp_ctrl[6] == 1'b0 && stalls < 65535) stalls++;
            if (dead) begin
                // stuck until reset
            end else if (waits > 0) begin
                if (i_ram_ready) begin
                    waits = 0; brp = 1'b0;
                end else begin
                    if (waits < WAIT_MAX) waits++;
                    brp = brp | i_branch_taken;
                    if (waits == WAIT_MAX) dead = 1'b1;
                end
            end else if (i_mem_req && !i_ram_ready) begin
                waits = 1; brp = i_branch_taken;
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, compare shortly after.
    task automatic step(input logic rsn, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic [RW-1:0] rd, input logic ram, input logic mreq,
                        input logic rdy, input logic br);
        @(negedge clk);
        rst_n = rsn; i_id_rs = rs; i_id_rt = rt; i_ex_rd = rd;
        i_ex_e_read_ram = ram; i_mem_req = mreq; i_ram_ready = rdy; i_branch_taken = br;
        #1;
        model_eval();
        chk("ctrl", 16'(act_ctrl), 16'(exp_ctrl));
        chk("stall_cycles", o_stall_cycles, exp_stalls);
        model_next();
    endtask

    task automatic idle();
        step(1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int          rdy_pct;
    int          dead_run;
    logic        rsn_r;
    logic [15:0] exp36;

    initial begin
        // Reset state.
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_ctrl", 16'(act_ctrl), 16'h0006);
        chk("reset_stalls", o_stall_cycles, 16'd0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load-use hazard: one bubble, then resume.
        step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_bubble", 16'(act_ctrl), 16'(7'b0011_01_0));
        step(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_resume", 16'(act_ctrl), 16'(7'b1111_00_0));

        // Register 0 never stalls.
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r0_nostall", 16'(act_ctrl), 16'(7'b1111_00_0));

        // Three wait cycles then ready.
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("wait3_hold", 16'(act_ctrl), 16'd0);
        end
        step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("wait3_ready", 16'(act_ctrl), 16'(7'b1111_00_0));
        idle();
`ifdef PIPE_CTRL_STATS_EN
        exp36 = 16'd3;
`else
        exp36 = 16'd0;
`endif
        chk("wait3_stalls", o_stall_cycles, exp36);

        // Branch during the 2nd wait cycle flushes only on the ready cycle.
        step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("brwait_2", 16'(act_ctrl), 16'd0);
        step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("brwait_3", 16'(act_ctrl), 16'd0);
        step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("brwait_ready", 16'(act_ctrl), 16'(7'b1111_11_0));

        // M, B and H together: RAM wait wins, branch remembered.
        step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("mbh_wait", 16'(act_ctrl), 16'd0);
        step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("mbh_ready", 16'(act_ctrl), 16'(7'b1111_11_0));

        // Reset during a wait discards the pending branch.
        step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_async", 16'(act_ctrl), 16'(7'b0000_11_0));
        step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_dropbr", 16'(act_ctrl), 16'(7'b1111_00_0));

        // Timeout after WAIT_MAX wait cycles, sticky until reset.
        for (int i = 0; i < WAIT_MAX; i++) begin
            step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("tmo_wait", 16'(act_ctrl), 16'd0);
        end
        step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("tmo_error", 16'(act_ctrl), 16'(7'b0000_00_1));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
            chk("tmo_sticky", 16'(act_ctrl), 16'(7'b0000_00_1));
        end
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tmo_clear", 16'(act_ctrl), 16'(7'b0000_11_0));
        idle();
        chk("tmo_run", 16'(act_ctrl), 16'(7'b1111_00_0));

        // Randomized traffic against the model.
        rdy_pct  = 50;
        dead_run = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) rdy_pct = ($urandom_range(0, 3) == 0) ? 5 : 50;
            rsn_r = 1'b1;
            if (dead_run > 3 || $urandom_range(0, 99) == 0) rsn_r = 1'b0;
            step(rsn_r,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 99) < rdy_pct),
                 ($urandom_range(0, 99) < 20));
            dead_run = dead ? dead_run + 1 : 0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
